// File: rtl/id_ex_reg_pkg.sv
// id_ex_reg_pkg
//   Shared widths and control encodings for the ID/EX pipeline register.
//   The defaults track the core-wide register address, datapath and ALU
//   opcode widths that aux_id also uses.
//   No ports: constants and types only.
package id_ex_reg_pkg;

  localparam int GPR_ADR_DEF = 5;
  localparam int GPR_BIT_DEF = 32;
  localparam int ALU_OP_DEF  = 4;
  localparam int CNT_BIT_DEF = 16;

  // Control bits carried down the pipe. A bubble is all-zero, which is
  // also the NOP control encoding.
  typedef struct packed {
    logic reg_we;
    logic mem_rd;
    logic mem_wr;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_reg_hazard_unit.sv
// hazard_unit
//   Combinational load-use detector. It flags an ID instruction that reads
//   a register which the load currently in EX has not yet produced.
//   Ports:
//     id_valid, id_addr_rs/rt, id_use_rs/rt   ID-side operand info
//     ex_valid, ex_mem_rd, ex_reg_we,
//     ex_addr_reg                             EX-side producer info
//     load_use                                hazard flag (out)
module hazard_unit
  import id_ex_reg_pkg::*;
#(
  parameter int GPR_ADR = GPR_ADR_DEF
) (
  input  logic               id_valid,
  input  logic [GPR_ADR-1:0] id_addr_rs,
  input  logic [GPR_ADR-1:0] id_addr_rt,
  input  logic               id_use_rs,
  input  logic               id_use_rt,
  input  logic               ex_valid,
  input  logic               ex_mem_rd,
  input  logic               ex_reg_we,
  input  logic [GPR_ADR-1:0] ex_addr_reg,
  output logic               load_use
);

  logic ex_load;
  logic rs_hit;
  logic rt_hit;

  // r0 is hardwired to zero, so a load targeting it produces nothing to wait for.
  assign ex_load  = ex_valid & ex_mem_rd & ex_reg_we & (ex_addr_reg != '0);
  assign rs_hit   = id_use_rs & (id_addr_rs == ex_addr_reg);
  assign rt_hit   = id_use_rt & (id_addr_rt == ex_addr_reg);
  assign load_use = id_valid & ex_load & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg
//   ID/EX pipeline register. It captures the decoded operands, the
//   destination address, the immediate and the control bits, and presents
//   them to EX one cycle later. It inserts bubbles on flush and on load-use
//   hazards, holds while EX is stalled, and counts load-use bubbles with a
//   saturating counter.
//   Ports:
//     clk, rst           clock, synchronous active-high reset
//     id_*               ID stage fields
//     ex_stall, flush    EX back-pressure and kill of the ID instruction
//     ex_*               registered copies of the id_* fields
//     id_stall           hold PC and IF/ID this cycle (combinational)
//     hazard_cnt         saturating count of load-use bubbles
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int GPR_ADR = GPR_ADR_DEF,
  parameter int GPR_BIT = GPR_BIT_DEF,
  parameter int ALU_OP  = ALU_OP_DEF,
  parameter int CNT_BIT = CNT_BIT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [GPR_BIT-1:0] id_pc,
  input  logic [GPR_ADR-1:0] id_addr_rs,
  input  logic [GPR_ADR-1:0] id_addr_rt,
  input  logic               id_use_rs,
  input  logic               id_use_rt,
  input  logic [GPR_ADR-1:0] id_addr_reg,
  input  logic [GPR_BIT-1:0] id_sext_imm,
  input  logic [GPR_BIT-1:0] id_data_rs,
  input  logic [GPR_BIT-1:0] id_data_rt,
  input  logic               id_reg_we,
  input  logic               id_mem_rd,
  input  logic               id_mem_wr,
  input  logic [ALU_OP-1:0]  id_alu_op,
  input  logic               ex_stall,
  input  logic               flush,
  output logic               ex_valid,
  output logic [GPR_BIT-1:0] ex_pc,
  output logic [GPR_ADR-1:0] ex_addr_rs,
  output logic [GPR_ADR-1:0] ex_addr_rt,
  output logic [GPR_ADR-1:0] ex_addr_reg,
  output logic [GPR_BIT-1:0] ex_sext_imm,
  output logic [GPR_BIT-1:0] ex_data_rs,
  output logic [GPR_BIT-1:0] ex_data_rt,
  output logic               ex_reg_we,
  output logic               ex_mem_rd,
  output logic               ex_mem_wr,
  output logic [ALU_OP-1:0]  ex_alu_op,
  output logic               id_stall,
  output logic [CNT_BIT-1:0] hazard_cnt
);

  logic  load_use;
  logic  flush_pend;
  logic  flush_eff;
  ctrl_t id_ctrl;

  hazard_unit #(.GPR_ADR(GPR_ADR)) u_hazard (
    .id_valid    (id_valid),
    .id_addr_rs  (id_addr_rs),
    .id_addr_rt  (id_addr_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .ex_valid    (ex_valid),
    .ex_mem_rd   (ex_mem_rd),
    .ex_reg_we   (ex_reg_we),
    .ex_addr_reg (ex_addr_reg),
    .load_use    (load_use)
  );

  // A flush that arrives while EX is stalled is remembered until the
  // registers are free to take the bubble.
  assign flush_eff = flush | flush_pend;
  // A killed ID instruction needs no stall; the flush bubble covers it.
  assign id_stall  = ex_stall | (load_use & ~flush_eff);
  assign id_ctrl   = '{reg_we: id_reg_we, mem_rd: id_mem_rd, mem_wr: id_mem_wr};

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_pend  <= 1'b0;
      hazard_cnt  <= '0;
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_addr_rs  <= '0;
      ex_addr_rt  <= '0;
      ex_addr_reg <= '0;
      ex_sext_imm <= '0;
      ex_data_rs  <= '0;
      ex_data_rt  <= '0;
      {ex_reg_we, ex_mem_rd, ex_mem_wr} <= CTRL_NOP;
      ex_alu_op   <= '0;
    end else if (ex_stall) begin
      if (flush) flush_pend <= 1'b1;
    end else begin
      flush_pend <= 1'b0;
      if (flush_eff || load_use) begin
        ex_valid    <= 1'b0;
        ex_pc       <= '0;
        ex_addr_rs  <= '0;
        ex_addr_rt  <= '0;
        ex_addr_reg <= '0;
        ex_sext_imm <= '0;
        ex_data_rs  <= '0;
        ex_data_rt  <= '0;
        {ex_reg_we, ex_mem_rd, ex_mem_wr} <= CTRL_NOP;
        ex_alu_op   <= '0;
        // Only hazard bubbles are counted; flush bubbles are not.
        if (!flush_eff && load_use && (hazard_cnt != '1))
          hazard_cnt <= hazard_cnt + 1'b1;
      end else begin
        ex_valid    <= id_valid;
        ex_pc       <= id_pc;
        ex_addr_rs  <= id_addr_rs;
        ex_addr_rt  <= id_addr_rt;
        ex_addr_reg <= id_addr_reg;
        ex_sext_imm <= id_sext_imm;
        ex_data_rs  <= id_data_rs;
        ex_data_rt  <= id_data_rt;
        {ex_reg_we, ex_mem_rd, ex_mem_wr} <= id_ctrl;
        ex_alu_op   <= id_alu_op;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_addr_rs, id_addr_rt, id_addr_reg;
  logic        id_use_rs, id_use_rt;
  logic [31:0] id_sext_imm, id_data_rs, id_data_rt;
  logic        id_reg_we, id_mem_rd, id_mem_wr;
  logic [3:0]  id_alu_op;
  logic        ex_stall, flush;

  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [4:0]  ex_addr_rs, ex_addr_rt, ex_addr_reg;
  logic [31:0] ex_sext_imm, ex_data_rs, ex_data_rt;
  logic        ex_reg_we, ex_mem_rd, ex_mem_wr;
  logic [3:0]  ex_alu_op;
  logic        id_stall;
  logic [15:0] hazard_cnt;

  // Second copy with a 2-bit counter for saturation; same stimulus.
  logic        ex_valid2;
  logic [31:0] ex_pc2;
  logic [4:0]  ex_addr_rs2, ex_addr_rt2, ex_addr_reg2;
  logic [31:0] ex_sext_imm2, ex_data_rs2, ex_data_rt2;
  logic        ex_reg_we2, ex_mem_rd2, ex_mem_wr2;
  logic [3:0]  ex_alu_op2;
  logic        id_stall2;
  logic [1:0]  hazard_cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_addr_rs(id_addr_rs), .id_addr_rt(id_addr_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_addr_reg(id_addr_reg), .id_sext_imm(id_sext_imm),
    .id_data_rs(id_data_rs), .id_data_rt(id_data_rt),
    .id_reg_we(id_reg_we), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
    .id_alu_op(id_alu_op), .ex_stall(ex_stall), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_addr_rs(ex_addr_rs),
    .ex_addr_rt(ex_addr_rt), .ex_addr_reg(ex_addr_reg),
    .ex_sext_imm(ex_sext_imm), .ex_data_rs(ex_data_rs),
    .ex_data_rt(ex_data_rt), .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_alu_op(ex_alu_op), .id_stall(id_stall),
    .hazard_cnt(hazard_cnt)
  );

  id_ex_reg #(.CNT_BIT(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_addr_rs(id_addr_rs), .id_addr_rt(id_addr_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_addr_reg(id_addr_reg), .id_sext_imm(id_sext_imm),
    .id_data_rs(id_data_rs), .id_data_rt(id_data_rt),
    .id_reg_we(id_reg_we), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
    .id_alu_op(id_alu_op), .ex_stall(ex_stall), .flush(flush),
    .ex_valid(ex_valid2), .ex_pc(ex_pc2), .ex_addr_rs(ex_addr_rs2),
    .ex_addr_rt(ex_addr_rt2), .ex_addr_reg(ex_addr_reg2),
    .ex_sext_imm(ex_sext_imm2), .ex_data_rs(ex_data_rs2),
    .ex_data_rt(ex_data_rt2), .ex_reg_we(ex_reg_we2), .ex_mem_rd(ex_mem_rd2),
    .ex_mem_wr(ex_mem_wr2), .ex_alu_op(ex_alu_op2), .id_stall(id_stall2),
    .hazard_cnt(hazard_cnt2)
  );

  // Reference model: the instruction sitting in EX, the pending-flush flag
  // and an unbounded bubble count that is clipped per counter width.
  typedef struct packed {
    bit        valid;
    bit [31:0] pc;
    bit [4:0]  rs, rt, rd;
    bit [31:0] imm, drs, drt;
    bit        we, ld, st;
    bit [3:0]  op;
  } instr_t;

  instr_t m_ex;
  bit     m_pend;
  int     m_bubbles;
  bit     started = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic instr_t id_instr();
    instr_t i;
    i = '{valid: id_valid, pc: id_pc, rs: id_addr_rs, rt: id_addr_rt,
          rd: id_addr_reg, imm: id_sext_imm, drs: id_data_rs, drt: id_data_rt,
          we: id_reg_we, ld: id_mem_rd, st: id_mem_wr, op: id_alu_op};
    return i;
  endfunction

  // ID depends on the load in EX: the load must really write a nonzero
  // register, and ID must actually read that register.
  function automatic bit model_load_use();
    bit depends;
    depends = (id_use_rs && id_addr_rs == m_ex.rd) || (id_use_rt && id_addr_rt == m_ex.rd);
    return id_valid && m_ex.valid && m_ex.ld && m_ex.we && (m_ex.rd != 0) && depends;
  endfunction

  // Apply the current inputs for one clock and compare everything.
  task automatic cycle();
    bit lu, kill;
    #1;
    lu   = model_load_use();
    kill = flush || m_pend;
    if (started) begin
      chk("id_stall", id_stall, ex_stall || (lu && !kill));
      chk("id_stall2", id_stall2, ex_stall || (lu && !kill));
    end
    if (rst) begin
      m_ex = '0; m_pend = 0; m_bubbles = 0;
    end else if (ex_stall) begin
      if (flush) m_pend = 1;
    end else begin
      m_pend = 0;
      if (kill) m_ex = '0;
      else if (lu) begin m_ex = '0; m_bubbles++; end
      else m_ex = id_instr();
    end
    @(posedge clk);
    #1;
    started = 1'b1;
    chk("ex_valid", ex_valid, m_ex.valid);
    chk("ex_pc", ex_pc, m_ex.pc);
    chk("ex_addr_rs", ex_addr_rs, m_ex.rs);
    chk("ex_addr_rt", ex_addr_rt, m_ex.rt);
    chk("ex_addr_reg", ex_addr_reg, m_ex.rd);
    chk("ex_sext_imm", ex_sext_imm, m_ex.imm);
    chk("ex_data_rs", ex_data_rs, m_ex.drs);
    chk("ex_data_rt", ex_data_rt, m_ex.drt);
    chk("ex_ctrl", {ex_reg_we, ex_mem_rd, ex_mem_wr}, {m_ex.we, m_ex.ld, m_ex.st});
    chk("ex_alu_op", ex_alu_op, m_ex.op);
    chk("ex_valid2", ex_valid2, m_ex.valid);
    chk("flush_pend", dut.flush_pend, m_pend);
    chk("hazard_cnt", hazard_cnt, (m_bubbles > 65535) ? 65535 : m_bubbles);
    chk("hazard_cnt2", hazard_cnt2, (m_bubbles > 3) ? 3 : m_bubbles);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; ex_stall = 0; flush = 0;
    id_valid = 0; id_pc = 0; id_addr_rs = 0; id_addr_rt = 0; id_addr_reg = 0;
    id_use_rs = 0; id_use_rt = 0; id_sext_imm = 0; id_data_rs = 0; id_data_rt = 0;
    id_reg_we = 0; id_mem_rd = 0; id_mem_wr = 0; id_alu_op = 0;
  endtask

  task automatic set_load(input logic [4:0] rd);
    id_valid = 1; id_pc = $urandom; id_addr_reg = rd; id_reg_we = 1; id_mem_rd = 1;
    id_mem_wr = 0; id_use_rs = 0; id_use_rt = 0; id_data_rs = $urandom;
  endtask

  task automatic set_user(input logic [4:0] rs, input logic use_rs,
                          input logic [4:0] rt, input logic use_rt);
    id_valid = 1; id_pc = $urandom; id_addr_reg = 5'd9; id_reg_we = 1; id_mem_rd = 0;
    id_addr_rs = rs; id_use_rs = use_rs; id_addr_rt = rt; id_use_rt = use_rt;
    id_alu_op = 4'd3; id_data_rt = $urandom;
  endtask

  initial begin
    m_ex = '0; m_pend = 0; m_bubbles = 0;
    idle();
    rst = 1;
    cycle(); cycle();
    chk("reset_valid", ex_valid, 0);
    chk("reset_cnt", hazard_cnt, 0);
    idle();

    // Capture of a plain instruction.
    id_valid = 1; id_addr_reg = 5; id_sext_imm = 32'hFFFFFF80; id_reg_we = 1;
    cycle();
    chk("cap_imm", ex_sext_imm, 64'hFFFFFF80);
    chk("cap_rd", ex_addr_reg, 5);

    // Load to r8 then a dependent rs reader: one bubble, then capture.
    set_load(8); cycle();
    set_user(8, 1, 0, 0);
    cycle();
    chk("lu_bubble", ex_valid, 0);
    cycle();
    chk("lu_captured", ex_addr_reg, 9);
    chk("lu_cnt", hazard_cnt, 1);

    // Load to r0 and an unused rt operand produce no stall.
    set_load(0); cycle();
    set_user(0, 1, 0, 1); cycle();
    set_load(8); cycle();
    set_user(1, 1, 8, 0); cycle();

    // EX stall for three cycles, then capture resumes.
    set_user(2, 1, 3, 1); ex_stall = 1;
    repeat (3) cycle();
    ex_stall = 0; cycle();

    // Flush under stall, stall released two cycles later.
    ex_stall = 1; flush = 1; cycle();
    flush = 0; cycle(); cycle();
    ex_stall = 0; cycle();
    chk("flush_bubble", ex_valid, 0);

    // Reset during stall with a flush pending.
    ex_stall = 1; flush = 1; cycle();
    flush = 0; rst = 1; cycle();
    chk("rst_pend", dut.flush_pend, 0);
    rst = 0; ex_stall = 0;

    // Five hazards saturate the 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      set_load(8); cycle();
      set_user(5, 0, 8, 1); cycle(); cycle();
    end
    chk("sat_cnt2", hazard_cnt2, 3);
    chk("sat_cnt", hazard_cnt, 5);

    // Random traffic over a small register set to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      ex_stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      id_valid = ($urandom_range(0, 7) != 0);
      id_pc = $urandom; id_sext_imm = $urandom;
      id_data_rs = $urandom; id_data_rt = $urandom;
      id_addr_rs = 5'($urandom_range(0, 3));
      id_addr_rt = 5'($urandom_range(0, 3));
      id_addr_reg = 5'($urandom_range(0, 3));
      id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
      id_reg_we = ($urandom_range(0, 3) != 0);
      id_mem_rd = 1'($urandom); id_mem_wr = 1'($urandom);
      id_alu_op = 4'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
